// File: rtl/lzrw1_pkg.sv
// Shared constants, item/state types and field-extract helpers for the
// LZRW1 decompressor.
//   HIST_AW : history address width (offset field width), depth 2**HIST_AW
//   LEN_W   : copy length field width
//   ITEM_W  : compressed item width (length field above offset field)
package lzrw1_pkg;

    localparam int unsigned HIST_AW = 12;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned ITEM_W  = HIST_AW + LEN_W;

    typedef enum logic {
        ITEM_LITERAL = 1'b0,
        ITEM_COPY    = 1'b1
    } item_t;

    typedef enum logic {
        IDLE,
        COPY
    } state_t;

    // Copy length is the encoded field plus one; one extra bit holds 2**LEN_W.
    function automatic logic [LEN_W:0] copy_length(input logic [ITEM_W-1:0] item);
        return {1'b0, item[ITEM_W-1 -: LEN_W]} + (LEN_W+1)'(1);
    endfunction

    function automatic logic [HIST_AW-1:0] copy_offset(input logic [ITEM_W-1:0] item);
        return item[HIST_AW-1:0];
    endfunction

endpackage

// File: rtl/lzrw1_history_ram.sv
// History ring buffer for the LZRW1 decompressor: one synchronous write port
// and one asynchronous read port, no reset (contents start unspecified).
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write byte
//   raddr : read address
//   rdata : read byte (combinational from raddr)
module lzrw1_history_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lzrw1_decompressor.sv
// Streaming LZRW1 decompressor. Accepts one 16-bit item per transfer (literal
// or copy) and emits one reconstructed byte per clock into a byte sink, while
// keeping a 2**HIST_AW byte history for copy items.
//   clock             : rising-edge clock
//   reset             : asynchronous active-low reset
//   data_in           : compressed item ({length-1, offset} or {-, literal})
//   control_word_in   : 0 = literal item, 1 = copy item
//   data_in_valid     : item present, sampled only while not busy
//   decompressed_byte : reconstructed byte (registered)
//   out_valid         : decompressed_byte valid this cycle (registered)
//   decompressor_busy : inputs ignored while high (registered)
module lzrw1_decompressor
    import lzrw1_pkg::*;
#(
    parameter int unsigned HIST_AW = lzrw1_pkg::HIST_AW,
    parameter int unsigned LEN_W   = lzrw1_pkg::LEN_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [HIST_AW+LEN_W-1:0] data_in,
    input  logic                     control_word_in,
    input  logic                     data_in_valid,
    output logic [7:0]               decompressed_byte,
    output logic                     out_valid,
    output logic                     decompressor_busy
);

    state_t             state, state_nx;
    logic [HIST_AW-1:0] wp, wp_nx;
    logic [HIST_AW-1:0] offset, offset_nx;
    logic [LEN_W:0]     count, count_nx;
    logic [7:0]         byte_nx;
    logic               valid_nx;
    logic               busy_nx;

    logic               we;
    logic [7:0]         wdata;
    logic [HIST_AW-1:0] raddr;
    logic [7:0]         rdata;

    item_t item;
    logic  accept;

    assign item   = item_t'(control_word_in);
    assign accept = data_in_valid && !decompressor_busy;

    lzrw1_history_ram #(
        .AW (HIST_AW)
    ) u_hist (
        .clock (clock),
        .we    (we),
        .waddr (wp),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Each copied byte is written back at wp on the same edge it is emitted,
    // so overlapping copies (offset < length) read bytes produced earlier in
    // the same copy.
    always_comb begin
        state_nx  = state;
        wp_nx     = wp;
        offset_nx = offset;
        count_nx  = count;
        byte_nx   = decompressed_byte;
        valid_nx  = 1'b0;
        busy_nx   = decompressor_busy;
        we        = 1'b0;
        wdata     = data_in[7:0];
        raddr     = wp - offset;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (item == ITEM_LITERAL) begin
                        byte_nx  = data_in[7:0];
                        valid_nx = 1'b1;
                        we       = 1'b1;
                        wdata    = data_in[7:0];
                        wp_nx    = wp + HIST_AW'(1);
                    end else begin
                        offset_nx = copy_offset(data_in);
                        count_nx  = copy_length(data_in);
                        state_nx  = COPY;
                        busy_nx   = 1'b1;
                    end
                end
            end
            COPY: begin
                byte_nx  = rdata;
                valid_nx = 1'b1;
                we       = 1'b1;
                wdata    = rdata;
                wp_nx    = wp + HIST_AW'(1);
                count_nx = count - (LEN_W+1)'(1);
                if (count == (LEN_W+1)'(1)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp                <= '0;
            offset            <= '0;
            count             <= '0;
            decompressed_byte <= '0;
            out_valid         <= 1'b0;
            decompressor_busy <= 1'b0;
        end else begin
            wp                <= wp_nx;
            offset            <= offset_nx;
            count             <= count_nx;
            decompressed_byte <= byte_nx;
            out_valid         <= valid_nx;
            decompressor_busy <= busy_nx;
        end
    end

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Directed bench for lzrw1_decompressor: reset, literals, copies (basic,
// overlapping max-length, wrap-around offset 4095) and reset during a copy.
module tb_lzrw1_decompressor;

    logic        clock;
    logic        reset;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        data_in_valid;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        decompressor_busy;

    int checks   = 0;
    int failures = 0;

    lzrw1_decompressor #(
        .HIST_AW (12),
        .LEN_W   (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .data_in_valid     (data_in_valid),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .decompressor_busy (decompressor_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle; inputs driven after this are sampled next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic valid, input logic cw, input logic [15:0] d);
        data_in_valid   = valid;
        control_word_in = cw;
        data_in         = d;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] b,
                              input logic busy);
        check({tag, "_valid"}, {15'd0, out_valid}, {15'd0, v});
        if (v) check({tag, "_byte"}, {8'd0, decompressed_byte}, {8'd0, b});
        check({tag, "_busy"}, {15'd0, decompressor_busy}, {15'd0, busy});
    endtask

    initial begin
        // Reset held with a valid item present
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("reset", 1'b0, 8'h00, 1'b0);
            check("reset_byte", {8'd0, decompressed_byte}, 16'h0000);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        step();
        expect_out("post_reset", 1'b0, 8'h00, 1'b0);

        // Literals "abc" back to back
        drive(1'b1, 1'b0, 16'h0061); step(); expect_out("lit_a", 1'b1, 8'h61, 1'b0);
        drive(1'b1, 1'b0, 16'hFF62); step(); expect_out("lit_b", 1'b1, 8'h62, 1'b0);
        drive(1'b1, 1'b0, 16'h0063); step(); expect_out("lit_c", 1'b1, 8'h63, 1'b0);

        // Basic copy L=3 offset=3
        drive(1'b1, 1'b1, 16'h2003); step(); expect_out("cp_acc", 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 16'h0000);
        step(); expect_out("cp0", 1'b1, 8'h61, 1'b1);
        step(); expect_out("cp1", 1'b1, 8'h62, 1'b1);
        step(); expect_out("cp2", 1'b1, 8'h63, 1'b0);
        drive(1'b1, 1'b0, 16'h0064); step(); expect_out("lit_d", 1'b1, 8'h64, 1'b0);

        // Overlapping max-length copy, inputs changed while busy
        drive(1'b1, 1'b0, 16'h0078); step(); expect_out("lit_x", 1'b1, 8'h78, 1'b0);
        drive(1'b1, 1'b1, 16'hF001); step(); expect_out("ov_acc", 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 16'h0099);
        for (int i = 0; i < 16; i++) begin
            step();
            expect_out("ov", 1'b1, 8'h78, (i != 15));
            if (i == 15) drive(1'b0, 1'b0, 16'h0000);
        end
        step();
        expect_out("ov_after", 1'b0, 8'h00, 1'b0);
        check("ov_hold", {8'd0, decompressed_byte}, 16'h0078);

        // 4100 literals, then copy offset 4095 reaching back to index 5
        for (int i = 0; i < 4100; i++) begin
            drive(1'b1, 1'b0, 16'(i % 256));
            step();
            if (i < 8 || i >= 4096)
                expect_out("wrap_lit", 1'b1, 8'(i % 256), 1'b0);
        end
        drive(1'b1, 1'b1, 16'h2FFF); step(); expect_out("wr_acc", 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 16'h0000);
        step(); expect_out("wr0", 1'b1, 8'h05, 1'b1);
        step(); expect_out("wr1", 1'b1, 8'h06, 1'b1);
        step(); expect_out("wr2", 1'b1, 8'h07, 1'b0);

        // Reset in the middle of a 16-byte copy
        drive(1'b1, 1'b1, 16'hF001); step(); expect_out("rm_acc", 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("rm_cp", 1'b1, 8'h07, 1'b1);
        end
        reset = 1'b0;
        #1;
        expect_out("rm_async", 1'b0, 8'h00, 1'b0);
        check("rm_byte", {8'd0, decompressed_byte}, 16'h0000);
        step(); step();
        expect_out("rm_hold", 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        step();
        expect_out("rm_idle", 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 16'h0041); step(); expect_out("rm_lit", 1'b1, 8'h41, 1'b0);

        // With wp restarted at 0, offset 4095 reads addresses 2,3,4, which hold
        // wrap literals 4074..4076 (written at (24+i) mod 4096).
        drive(1'b1, 1'b1, 16'h2FFF); step(); expect_out("wp_acc", 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 16'h0000);
        step(); expect_out("wp0", 1'b1, 8'hEA, 1'b1);
        step(); expect_out("wp1", 1'b1, 8'hEB, 1'b1);
        step(); expect_out("wp2", 1'b1, 8'hEC, 1'b0);
        step(); expect_out("end_idle", 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lzrw1_decompressor.md
Name: lzrw1_decompressor

Overview:
Streaming LZRW1 decompressor core. It consumes one 16-bit compressed item per accepted transfer, tagged by a control bit as either a literal or a copy item, and emits reconstructed bytes one per clock. A 4096-byte history ring buffer holds previously emitted bytes for copy items. It sits between the compressed-item source (with flow control via busy) and the byte sink.

Parameters:
HIST_AW, 12, history address width; depth = 2**HIST_AW bytes; offset field width.
LEN_W, 4, copy length field width.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; 0 = in reset.
data_in  input  16  compressed item.
control_word_in  input  1  0 = literal item, 1 = copy item.
data_in_valid  input  1  item present; sampled only while decompressor_busy=0.
decompressed_byte  output  8  reconstructed byte; registered.
out_valid  output  1  decompressed_byte valid this cycle; registered.
decompressor_busy  output  1  1 = inputs ignored; registered.

Behaviour:
- Reset (reset=0, async): out_valid=0, decompressed_byte=8'h00, decompressor_busy=0, write pointer wp=0, FSM=IDLE. A copy in progress is aborted. History RAM is not cleared; its contents after reset are unspecified.
- Accept: rising edge with data_in_valid=1 and busy=0. While busy=1, inputs are ignored and not queued.
- Literal (control_word_in=0): data_in[7:0] is the byte; data_in[15:8] is ignored. On the accept edge: decompressed_byte<=byte, out_valid<=1, hist[wp]<=byte, wp<=wp+1. Latency is 1 cycle. Back-to-back literals give one byte per cycle; busy stays 0.
- Copy (control_word_in=1): length L = data_in[15:12]+1 (legal 3..16); offset = data_in[11:0] (legal 1..4095).
  - Accept edge: latch offset, count<=L, FSM<=COPY, busy<=1, out_valid<=0.
  - Each edge in COPY: b = hist[wp-offset] (mod 4096, asynchronous read). decompressed_byte<=b, out_valid<=1, hist[wp]<=b, wp++, count--.
  - Edge emitting the last byte: FSM<=IDLE, busy<=0.
  - out_valid is high for exactly L consecutive cycles, starting 2 cycles after the accept edge.
  - The next item can be accepted on the edge after busy falls.
- Overlapping copies (offset < L) replicate bytes naturally, because each byte is written before later reads.
- Idle cycles (no accept, FSM=IDLE): out_valid<=0; decompressed_byte holds its last value.
- Out-of-range fields get no special handling:
  - Field values 0/1 give L=1/2.
  - Offset 0 reads hist[wp], which is stale.
  - Offsets reaching unwritten locations return unspecified data.
- wp and read addresses wrap modulo 4096.
- FSM states: IDLE and COPY only.

Decomposition:
- Package lzrw1_pkg holds:
  - HIST_AW and LEN_W constants.
  - The item-type enum {ITEM_LITERAL=0, ITEM_COPY=1}.
  - FSM state enum {IDLE, COPY}.
  - Field-extract helper functions for length and offset.
- One sub-module, lzrw1_history_ram: 4096x8, one synchronous write port and one asynchronous read port; no reset.

Test Plan:
- Reset: hold reset=0 for 3 cycles with data_in_valid=1 -> out_valid=0, busy=0, decompressed_byte=00. Release -> still idle, no output.
- Literals: 0x0061, 0x0062, 0x0063 with cw=0 on consecutive cycles -> out_valid on 3 consecutive cycles with bytes 61, 62, 63; busy never asserts.
- Basic copy: after "abc", send cw=1 data 0x2003 (L=3, offset=3) -> busy=1, then 61 62 63 on 3 consecutive cycles. Then busy=0, and a following literal 0x0064 is output 64.
- Overlap and max length: literal 0x0078, then copy 0xF001 (L=16, offset=1) -> sixteen 78 bytes. Change data_in while busy -> ignored, no extra output.
- Wrap-around: 4100 literals (value = index mod 256), then copy 0x2FFF (offset 4095) -> bytes equal to the literals at indices 5, 6, 7.
- Reset mid-copy: assert reset during a 16-byte copy -> out_valid and busy drop immediately. After release, literal 0x0041 yields 41 with wp restarted at 0.
